sa_psum_drain: RTL and testbench
================================

// Module: sa_psum_drain
// PURPOSE
// - Downstream stage of the systolic PE array: drains accumulated psums after compute.
// - Drives the array's psum shift-left enable, one column per cycle.
// - Samples the left-edge psum vector (one value per row) and buffers it in an internal FIFO.
// - Streams the buffered columns out over a valid/ready interface to the writeback logic.
// PARAMETERS
// - DATA_WIDTH  8  PE operand width; psum width is DATA_WIDTH*2.
// - ROWS        4  array rows = psums per column vector.
// - COLS        4  array columns = shifts per drain; must be >= 1.
// - FIFO_DEPTH  4  column-vector FIFO entries; must be a power of 2 and >= 2.
// PORTS
// - i_clk           in   1                      clock; all state on rising edge.
// - i_nrst          in   1                      async active-low reset.
// - i_start         in   1                      pulse: compute finished, begin drain.
// - i_flush         in   1                      sync abort: back to IDLE, FIFO emptied.
// - i_edge_psum     in   ROWS*DATA_WIDTH*2      left-edge PE o_ofmap values, row r at [r*2DW +: 2DW].
// - o_psum_out_en   out  1                      shift enable to every PE (i_psum_out_en).
// - o_drain_active  out  1                      high in DRAIN; top level must hold PE i_pe_en low.
// - o_data          out  ROWS*DATA_WIDTH*2      FIFO head column vector.
// - o_col_idx       out  $clog2(COLS)+1         column index of the head entry (0 = original leftmost).
// - o_last          out  1                      head entry is column COLS-1.
// - o_valid         out  1                      FIFO non-empty.
// - i_ready         in   1                      consumer accepts the head when o_valid & i_ready.
// - o_done          out  1                      1-cycle pulse when the final column is pushed.
// BEHAVIOUR
// - Reset: state IDLE, column counter 0, FIFO empty.
// - Reset values of outputs: all outputs 0 (o_data 0, o_valid 0, o_done 0).
// - FSM IDLE: on i_start & ~i_flush, go to DRAIN with col_cnt=0; otherwise stay.
// - FSM DRAIN: o_drain_active=1.
//   - push = (fifo_count < FIFO_DEPTH); no full-bypass, even when a pop happens the same cycle.
//   - On push: write {i_edge_psum, col_cnt, col_cnt==COLS-1} into the FIFO; col_cnt++.
//   - o_psum_out_en = push & (col_cnt != COLS-1); combinational from state/count, no glitch on data.
//   - Sample and shift share one clock edge, so each push captures the pre-shift column.
//   - Throughput: 1 column/cycle while not full; a full FIFO stalls push and shift together (no column lost).
//   - After pushing col COLS-1: o_done pulses in that same cycle; next state IDLE.
// - FSM DONE is implicit: returns to IDLE. i_start while in DRAIN is ignored.
// - FIFO:
//   - A pushed entry appears on o_valid the next cycle.
//   - Pop on o_valid & i_ready.
//   - Simultaneous push and pop keeps the count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - o_data, o_col_idx and o_last are held stable while o_valid & ~i_ready.
// - i_flush (any state): next cycle IDLE, FIFO empty, col_cnt 0.
//   - o_psum_out_en and o_done are forced 0 in the flush cycle.
//   - Flush wins over i_start and over a pending push or pop.
// - Arithmetic: psums pass through unmodified, no truncation; width is exactly DATA_WIDTH*2 per row.
// - Async reset mid-drain: immediate return to reset values; partially drained data is discarded.
// CONFIGURATION
// - Macro SA_PSUM_DRAIN_STALL_CNT_EN.
// - Defined: adds port o_stall_cycles, out, 32 bits.
//   - Counts DRAIN cycles where push is blocked by a full FIFO.
//   - Cleared on i_start accept and on i_flush; saturates at 2^32-1.
// - Undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Setup for all scenarios: DW=8, ROWS=2, COLS=3, DEPTH=4; a PE array model is driven by o_psum_out_en.
// 1. Happy path: array cols = {0x0102,0x0304}, {0x0506,0x0708}, {0x090A,0x0B0C}; i_ready=1; i_start.
//    -> o_psum_out_en high for 2 cycles.
//    -> 3 outputs in order with col_idx 0,1,2; o_last on the 3rd.
//    -> o_done one cycle after DRAIN entry + 2.
// 2. Backpressure: DEPTH=2, i_ready=0 during the drain.
//    -> 2 pushes, then stall with o_psum_out_en=0.
//    -> Releasing i_ready completes the drain with no loss or duplication.
//    -> With the macro defined, o_stall_cycles equals the blocked cycles.
// 3. i_ready toggling 1,0,1,0 every cycle.
//    -> o_data stable while stalled; total of 3 accepts; order preserved.
// 4. i_flush at the second DRAIN cycle with 1 entry buffered.
//    -> Next cycle o_valid=0, IDLE, no o_done.
//    -> A new i_start drains all 3 columns correctly.
// 5. i_start pulsed again mid-DRAIN.
//    -> Ignored; exactly 3 pushes.
//    -> i_start and i_flush asserted together in IDLE -> stays IDLE.
// 6. Assert i_nrst low mid-drain.
//    -> All outputs 0 immediately (async).
//    -> After release, IDLE with o_valid=0.

Source files
------------

// File: rtl/sa_psum_drain.sv
// Drains accumulated psums from the systolic array one column per cycle into a small FIFO.
// Optional macro SA_PSUM_DRAIN_STALL_CNT_EN adds the o_stall_cycles full-FIFO stall counter.
module sa_psum_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic                           i_start,
    input  logic                           i_flush,
    input  logic [ROWS*DATA_WIDTH*2-1:0]   i_edge_psum,
    output logic                           o_psum_out_en,
    output logic                           o_drain_active,
    output logic [ROWS*DATA_WIDTH*2-1:0]   o_data,
    output logic [$clog2(COLS):0]          o_col_idx,
    output logic                           o_last,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_done
`ifdef SA_PSUM_DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]                    o_stall_cycles
`endif
);

    localparam int PSUM_W = ROWS * DATA_WIDTH * 2;
    localparam int IDX_W  = $clog2(COLS) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   col_cnt;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PSUM_W-1:0]  mem_data [FIFO_DEPTH];
    logic [IDX_W-1:0]   mem_idx  [FIFO_DEPTH];
    logic               mem_last [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic               last_col;
    logic               fifo_full;
    logic               start_accept;

    assign last_col  = (col_cnt == IDX_W'(COLS - 1));
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

    // Push is decided from the current count only, so a same-cycle pop never frees a slot early.
    always_comb begin
        next_state    = state;
        push          = 1'b0;
        start_accept  = 1'b0;
        o_psum_out_en = 1'b0;
        o_done        = 1'b0;
        case (state)
            IDLE: begin
                if (i_start && !i_flush) begin
                    next_state   = DRAIN;
                    start_accept = 1'b1;
                end
            end
            DRAIN: begin
                if (!i_flush && !fifo_full) begin
                    push          = 1'b1;
                    o_psum_out_en = !last_col;
                    o_done        = last_col;
                    if (last_col) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (i_flush) begin
            next_state = IDLE;
        end
    end

    assign o_drain_active = (state == DRAIN);
    assign o_valid        = (fifo_count != '0);
    assign pop            = o_valid && i_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= IDLE;
            col_cnt <= '0;
        end else begin
            state <= next_state;
            if (i_flush || start_accept) begin
                col_cnt <= '0;
            end else if (push) begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Storage is reset too so the head outputs read zero after reset.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
                mem_last[i] <= 1'b0;
            end
        end else if (i_flush) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= i_edge_psum;
                mem_idx[wr_ptr]  <= col_cnt;
                mem_last[wr_ptr] <= last_col;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign o_data    = mem_data[rd_ptr];
    assign o_col_idx = mem_idx[rd_ptr];
    assign o_last    = mem_last[rd_ptr];

`ifdef SA_PSUM_DRAIN_STALL_CNT_EN
    logic stall;
    assign stall = (state == DRAIN) && !i_flush && fifo_full;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_stall_cycles <= '0;
        end else if (i_flush || start_accept) begin
            o_stall_cycles <= '0;
        end else if (stall && (o_stall_cycles != '1)) begin
            o_stall_cycles <= o_stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_psum_drain.sv
// Directed testbench for sa_psum_drain: DUT a (FIFO_DEPTH=4) and DUT b (FIFO_DEPTH=2, backpressure),
// each fed by a behavioural 2x3 PE-array model shifted by o_psum_out_en.
module tb_sa_psum_drain;

    localparam int DW   = 8;
    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int PW   = ROWS * DW * 2;
    localparam int IW   = $clog2(COLS) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nrst, flush;
    logic          start_a, ready_a, load_a, start_b, ready_b, load_b;
    logic [PW-1:0] edge_a, edge_b, data_a, data_b;
    logic [IW-1:0] idx_a, idx_b;
    logic          en_a, act_a, last_a, valid_a, done_a;
    logic          en_b, act_b, last_b, valid_b, done_b;
`ifdef SA_PSUM_DRAIN_STALL_CNT_EN
    logic [31:0]   stall_a, stall_b;
`endif

    sa_psum_drain #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(4)) dut_a (
        .i_clk(clk), .i_nrst(nrst), .i_start(start_a), .i_flush(flush), .i_edge_psum(edge_a),
        .o_psum_out_en(en_a), .o_drain_active(act_a), .o_data(data_a), .o_col_idx(idx_a),
        .o_last(last_a), .o_valid(valid_a), .i_ready(ready_a), .o_done(done_a)
`ifdef SA_PSUM_DRAIN_STALL_CNT_EN
        , .o_stall_cycles(stall_a)
`endif
    );

    sa_psum_drain #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(2)) dut_b (
        .i_clk(clk), .i_nrst(nrst), .i_start(start_b), .i_flush(flush), .i_edge_psum(edge_b),
        .o_psum_out_en(en_b), .o_drain_active(act_b), .o_data(data_b), .o_col_idx(idx_b),
        .o_last(last_b), .o_valid(valid_b), .i_ready(ready_b), .o_done(done_b)
`ifdef SA_PSUM_DRAIN_STALL_CNT_EN
        , .o_stall_cycles(stall_b)
`endif
    );

    // PE array models: load the three columns, or shift left when the DUT enables it.
    logic [15:0] arr_a [COLS][ROWS];
    logic [15:0] arr_b [COLS][ROWS];

    always @(posedge clk) begin
        if (load_a) begin
            arr_a[0][0] <= 16'h0102; arr_a[0][1] <= 16'h0304;
            arr_a[1][0] <= 16'h0506; arr_a[1][1] <= 16'h0708;
            arr_a[2][0] <= 16'h090A; arr_a[2][1] <= 16'h0B0C;
        end else if (en_a) begin
            for (int c = 0; c < COLS - 1; c++)
                for (int r = 0; r < ROWS; r++) arr_a[c][r] <= arr_a[c+1][r];
            arr_a[COLS-1][0] <= 16'h0; arr_a[COLS-1][1] <= 16'h0;
        end
    end

    always @(posedge clk) begin
        if (load_b) begin
            arr_b[0][0] <= 16'h0102; arr_b[0][1] <= 16'h0304;
            arr_b[1][0] <= 16'h0506; arr_b[1][1] <= 16'h0708;
            arr_b[2][0] <= 16'h090A; arr_b[2][1] <= 16'h0B0C;
        end else if (en_b) begin
            for (int c = 0; c < COLS - 1; c++)
                for (int r = 0; r < ROWS; r++) arr_b[c][r] <= arr_b[c+1][r];
            arr_b[COLS-1][0] <= 16'h0; arr_b[COLS-1][1] <= 16'h0;
        end
    end

    assign edge_a = {arr_a[0][1], arr_a[0][0]};
    assign edge_b = {arr_b[0][1], arr_b[0][0]};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [PW-1:0] qd_a[$], qd_b[$];
    logic [IW-1:0] qi_a[$], qi_b[$];
    logic          ql_a[$], ql_b[$];
    int en_cnt_a, done_cnt_a, done_cyc_a, act_cnt_a, en_cnt_b, done_cnt_b;

    function automatic logic [PW-1:0] exp_col(int k);
        case (k)
            0:       return 32'h0304_0102;
            1:       return 32'h0708_0506;
            default: return 32'h0B0C_090A;
        endcase
    endfunction

    task automatic clear_rec();
        qd_a.delete(); qi_a.delete(); ql_a.delete();
        qd_b.delete(); qi_b.delete(); ql_b.delete();
        en_cnt_a = 0; done_cnt_a = 0; done_cyc_a = -1; act_cnt_a = 0;
        en_cnt_b = 0; done_cnt_b = 0;
    endtask

    // One cycle: sample at the falling edge, record activity, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (valid_a && ready_a) begin qd_a.push_back(data_a); qi_a.push_back(idx_a); ql_a.push_back(last_a); end
        if (valid_b && ready_b) begin qd_b.push_back(data_b); qi_b.push_back(idx_b); ql_b.push_back(last_b); end
        if (en_a) en_cnt_a++;
        if (act_a) act_cnt_a++;
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (en_b) en_cnt_b++;
        if (done_b) done_cnt_b++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; flush = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; load_a = 1'b0;
        start_b = 1'b0; ready_b = 1'b0; load_b = 1'b0;
        #3;
        checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", en_a); end
        checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b expected 0", act_a); end
        checks++; if (data_a !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", data_a); end
        checks++; if (idx_a !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx_a); end
        checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b/%0b expected 0/0", valid_a, valid_b); end
        checks++; if (done_a !== 1'b0 || last_a !== 1'b0) begin errors++; $display("FAIL reset_done_last: got %0b/%0b expected 0/0", done_a, last_a); end
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        tick();
        checks++; if (act_cnt_a !== 0) begin errors++; $display("FAIL reset_idle: got %0d active cycles expected 0", act_cnt_a); end
`ifdef SA_PSUM_DRAIN_STALL_CNT_EN
        checks++; if (stall_a !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_a); end
`endif
    endtask

    task automatic test_happy_path();
        clear_rec();
        ready_a = 1'b1; load_a = 1'b1; start_a = 1'b1;
        tick();
        begin
            int c0;
            c0 = cyc;
            load_a = 1'b0; start_a = 1'b0;
            repeat (8) tick();
            checks++; if (en_cnt_a !== 2) begin errors++; $display("FAIL happy_en_cycles: got %0d expected 2", en_cnt_a); end
            checks++; if (act_cnt_a !== 3) begin errors++; $display("FAIL happy_active_cycles: got %0d expected 3", act_cnt_a); end
            checks++; if (done_cnt_a !== 1) begin errors++; $display("FAIL happy_done_count: got %0d expected 1", done_cnt_a); end
            checks++; if (done_cyc_a !== c0 + 3) begin errors++; $display("FAIL happy_done_cycle: got %0d expected %0d", done_cyc_a, c0 + 3); end
        end
        checks++; if (qd_a.size() !== 3) begin errors++; $display("FAIL happy_accepts: got %0d expected 3", qd_a.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < qd_a.size()) begin
                checks++; if (qd_a[k] !== exp_col(k)) begin errors++; $display("FAIL happy_data%0d: got %0h expected %0h", k, qd_a[k], exp_col(k)); end
                checks++; if (qi_a[k] !== IW'(k)) begin errors++; $display("FAIL happy_idx%0d: got %0d expected %0d", k, qi_a[k], k); end
                checks++; if (ql_a[k] !== (k == 2)) begin errors++; $display("FAIL happy_last%0d: got %0b expected %0b", k, ql_a[k], k == 2); end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_rec();
        ready_b = 1'b0; load_b = 1'b1; start_b = 1'b1;
        tick();
        load_b = 1'b0; start_b = 1'b0;
        tick();
        tick();
        checks++; if (en_cnt_b !== 2) begin errors++; $display("FAIL bp_pushes_before_stall: got %0d shifts expected 2", en_cnt_b); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (en_b !== 1'b0 || valid_b !== 1'b1) begin errors++; $display("FAIL bp_stall%0d: got en=%0b valid=%0b expected en=0 valid=1", i, en_b, valid_b); end
            @(posedge clk); #1;
        end
        ready_b = 1'b1;
        repeat (6) tick();
        checks++; if (qd_b.size() !== 3) begin errors++; $display("FAIL bp_accepts: got %0d expected 3", qd_b.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < qd_b.size()) begin
                checks++; if (qd_b[k] !== exp_col(k) || qi_b[k] !== IW'(k)) begin errors++; $display("FAIL bp_entry%0d: got %0h/%0d expected %0h/%0d", k, qd_b[k], qi_b[k], exp_col(k), k); end
            end
        end
        checks++; if (en_cnt_b !== 2 || done_cnt_b !== 1) begin errors++; $display("FAIL bp_totals: got en=%0d done=%0d expected en=2 done=1", en_cnt_b, done_cnt_b); end
`ifdef SA_PSUM_DRAIN_STALL_CNT_EN
        checks++; if (stall_b !== 32'd5) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_b); end
`endif
        ready_b = 1'b0;
    endtask

    task automatic test_ready_toggle();
        clear_rec();
        ready_a = 1'b0; load_a = 1'b1; start_a = 1'b1;
        tick();
        load_a = 1'b0; start_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ready_a = (i % 2 == 0);
            @(negedge clk);
            if (valid_a && !ready_a) begin
                checks++; if (data_a !== exp_col(qd_a.size()) || idx_a !== IW'(qd_a.size())) begin errors++; $display("FAIL toggle_hold%0d: got %0h/%0d expected %0h/%0d", i, data_a, idx_a, exp_col(qd_a.size()), qd_a.size()); end
            end
            if (valid_a && ready_a) begin qd_a.push_back(data_a); qi_a.push_back(idx_a); ql_a.push_back(last_a); end
            @(posedge clk); #1;
        end
        checks++; if (qd_a.size() !== 3) begin errors++; $display("FAIL toggle_accepts: got %0d expected 3", qd_a.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < qd_a.size()) begin
                checks++; if (qd_a[k] !== exp_col(k) || ql_a[k] !== (k == 2)) begin errors++; $display("FAIL toggle_entry%0d: got %0h/%0b expected %0h/%0b", k, qd_a[k], ql_a[k], exp_col(k), k == 2); end
            end
        end
        ready_a = 1'b0;
    endtask

    task automatic test_flush();
        clear_rec();
        ready_a = 1'b0; load_a = 1'b1; start_a = 1'b1;
        tick();
        load_a = 1'b0; start_a = 1'b0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (en_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL flush_forced: got en=%0b done=%0b expected 0/0", en_a, done_a); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL flush_buffered: got valid=%0b expected 1", valid_a); end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++; if (valid_a !== 1'b0 || act_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL flush_after: got valid=%0b active=%0b done=%0b expected 0/0/0", valid_a, act_a, done_a); end
        @(posedge clk); #1;
        clear_rec();
        ready_a = 1'b1; load_a = 1'b1; start_a = 1'b1;
        tick();
        load_a = 1'b0; start_a = 1'b0;
        repeat (8) tick();
        checks++; if (qd_a.size() !== 3 || done_cnt_a !== 1) begin errors++; $display("FAIL flush_redrain: got %0d accepts %0d done expected 3/1", qd_a.size(), done_cnt_a); end
        for (int k = 0; k < 3; k++) begin
            if (k < qd_a.size()) begin
                checks++; if (qd_a[k] !== exp_col(k) || qi_a[k] !== IW'(k)) begin errors++; $display("FAIL flush_redrain%0d: got %0h/%0d expected %0h/%0d", k, qd_a[k], qi_a[k], exp_col(k), k); end
            end
        end
    endtask

    task automatic test_restart_ignored();
        clear_rec();
        ready_a = 1'b1; load_a = 1'b1; start_a = 1'b1;
        tick();
        load_a = 1'b0; start_a = 1'b0;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (8) tick();
        checks++; if (qd_a.size() !== 3) begin errors++; $display("FAIL restart_accepts: got %0d expected 3", qd_a.size()); end
        checks++; if (en_cnt_a !== 2 || done_cnt_a !== 1) begin errors++; $display("FAIL restart_totals: got en=%0d done=%0d expected 2/1", en_cnt_a, done_cnt_a); end
        for (int k = 0; k < 3; k++) begin
            if (k < qd_a.size()) begin
                checks++; if (qd_a[k] !== exp_col(k)) begin errors++; $display("FAIL restart_data%0d: got %0h expected %0h", k, qd_a[k], exp_col(k)); end
            end
        end
        clear_rec();
        start_a = 1'b1; flush = 1'b1;
        tick();
        start_a = 1'b0; flush = 1'b0;
        repeat (3) tick();
        checks++; if (act_cnt_a !== 0 || en_cnt_a !== 0 || qd_a.size() !== 0) begin errors++; $display("FAIL start_with_flush: got active=%0d en=%0d accepts=%0d expected 0/0/0", act_cnt_a, en_cnt_a, qd_a.size()); end
    endtask

    task automatic test_async_reset();
        clear_rec();
        ready_a = 1'b0; load_a = 1'b1; start_a = 1'b1;
        tick();
        load_a = 1'b0; start_a = 1'b0;
        tick();
        tick();
        #2;
        checks++; if (valid_a !== 1'b1 || act_a !== 1'b1) begin errors++; $display("FAIL areset_pre: got valid=%0b active=%0b expected 1/1", valid_a, act_a); end
        nrst = 1'b0;
        #1;
        checks++; if (en_a !== 1'b0 || act_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL areset_ctrl: got en=%0b active=%0b done=%0b expected 0/0/0", en_a, act_a, done_a); end
        checks++; if (valid_a !== 1'b0 || data_a !== '0 || idx_a !== '0 || last_a !== 1'b0) begin errors++; $display("FAIL areset_head: got valid=%0b data=%0h idx=%0d last=%0b expected all 0", valid_a, data_a, idx_a, last_a); end
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (valid_a !== 1'b0 || act_a !== 1'b0 || en_a !== 1'b0) begin errors++; $display("FAIL areset_after: got valid=%0b active=%0b en=%0b expected 0/0/0", valid_a, act_a, en_a); end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_backpressure();
        test_ready_toggle();
        test_flush();
        test_restart_ignored();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
